// File: rtl/mem_arb_pkg.sv
// Shared types and encodings for the two-port memory bus arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_LDR = 1'b1;
    localparam logic RW_READ = 1'b1;

endpackage

// File: rtl/mem_arb_rr.sv
// Combinational 2-way round-robin picker: on a tie the port that did not
// own the bus last time wins.
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic req_cpu,
    input  logic req_ldr,
    input  logic last_owner,
    output logic grant_valid,
    output logic grant_id
);

    // Pick a grantee; the tie-break flips away from the previous owner.
    always_comb begin
        grant_valid = req_cpu | req_ldr;
        grant_id    = OWN_CPU;
        if (req_cpu && req_ldr)
            grant_id = (last_owner == OWN_CPU) ? OWN_LDR : OWN_CPU;
        else if (req_ldr)
            grant_id = OWN_LDR;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (CPU / loader) memory bus arbiter with round-robin fairness.
// Optional BUS-state timeout abort is enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W         = 64,
    parameter int DATA_W         = 64,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_rw,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ldr_req,
    input  logic              ldr_rw,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_ack,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              mem_valid,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              owner,
    output logic              err
);

    state_t            state_q, state_d;
    logic              owner_q, last_owner_q;
    logic              lat_rw;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] cpu_rdata_q, ldr_rdata_q;
    logic              grant_valid, grant_id;
    logic              grant_take;
    logic              tmo_hit;

    mem_arb_rr u_rr (
        .req_cpu     (cpu_req),
        .req_ldr     (ldr_req),
        .last_owner  (last_owner_q),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] bus_cnt;
    logic             err_q;

    // Count BUS cycles from zero on each entry; latch whether the exit was an abort.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            if (grant_take)
                bus_cnt <= '0;
            else if (state_q == BUS)
                bus_cnt <= bus_cnt + CNT_W'(1);
            if (state_q == BUS)
                err_q <= tmo_hit;
        end
    end

    assign err = (state_q == RESP) && err_q;
`else
    logic unused_tmo;
    assign unused_tmo = (TIMEOUT_CYCLES == 0);
    assign err        = 1'b0;
`endif

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; a ready in the final timeout cycle beats the abort.
    always_comb begin
        state_d    = state_q;
        grant_take = 1'b0;
        tmo_hit    = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    state_d    = BUS;
                    grant_take = 1'b1;
                end
            end
            BUS: begin
                if (mem_ready) begin
                    state_d = RESP;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (bus_cnt == CNT_LAST) begin
                    state_d = RESP;
                    tmo_hit = 1'b1;
                end
`endif
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Latch the granted request, capture read data, update the fairness pointer.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            owner_q      <= OWN_CPU;
            last_owner_q <= OWN_LDR;
            lat_rw       <= RW_READ;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            cpu_rdata_q  <= '0;
            ldr_rdata_q  <= '0;
        end else begin
            if (grant_take) begin
                owner_q   <= grant_id;
                lat_rw    <= (grant_id == OWN_LDR) ? ldr_rw    : cpu_rw;
                lat_addr  <= (grant_id == OWN_LDR) ? ldr_addr  : cpu_addr;
                lat_wdata <= (grant_id == OWN_LDR) ? ldr_wdata : cpu_wdata;
            end
            if (state_q == BUS && lat_rw == RW_READ) begin
                if (mem_ready) begin
                    if (owner_q == OWN_LDR) ldr_rdata_q <= mem_rdata;
                    else                    cpu_rdata_q <= mem_rdata;
                end else if (tmo_hit) begin
                    if (owner_q == OWN_LDR) ldr_rdata_q <= '1;
                    else                    cpu_rdata_q <= '1;
                end
            end
            if (state_q == RESP)
                last_owner_q <= owner_q;
        end
    end

    assign mem_valid = (state_q == BUS);
    assign mem_rw    = lat_rw;
    assign mem_addr  = lat_addr;
    assign mem_wdata = (lat_rw == RW_READ) ? '0 : lat_wdata;
    assign owner     = owner_q;
    assign cpu_ack   = (state_q == RESP) && (owner_q == OWN_CPU);
    assign ldr_ack   = (state_q == RESP) && (owner_q == OWN_LDR);
    assign cpu_rdata = cpu_rdata_q;
    assign ldr_rdata = ldr_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (timeout cases with MEM_ARB_TIMEOUT_EN).
module tb_mem_arbiter;

    localparam int AW = 64;
    localparam int DW = 64;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          cpu_req = 1'b0, cpu_rw = 1'b1;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;
    logic          ldr_req = 1'b0, ldr_rw = 1'b1;
    logic [AW-1:0] ldr_addr = '0;
    logic [DW-1:0] ldr_wdata = '0;
    logic          ldr_ack;
    logic [DW-1:0] ldr_rdata;
    logic          mem_valid, mem_rw;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          owner, err;

    int errors = 0;
    int checks = 0;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(16)) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .ldr_req(ldr_req), .ldr_rw(ldr_rw), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata),
        .mem_valid(mem_valid), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .owner(owner), .err(err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge, then land on the falling edge for sampling/driving.
    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        // ---- reset state ----
        @(negedge clock);
        check("rst_valid", 64'(mem_valid), 64'd0);
        check("rst_acks",  64'({cpu_ack, ldr_ack, err}), 64'd0);
        check("rst_addr",  mem_addr, 64'd0);
        check("rst_wdata", mem_wdata, 64'd0);
        check("rst_rdata", cpu_rdata | ldr_rdata, 64'd0);
        check("rst_rw",    64'(mem_rw), 64'd1);
        check("rst_owner", 64'(owner), 64'd0);
        tick();
        reset = 1'b1;
        tick();

        // ---- ready outside BUS is ignored ----
        mem_ready = 1'b1;
        tick();
        check("idle_ready", 64'({mem_valid, cpu_ack, ldr_ack}), 64'd0);

        // ---- CPU read 0x40, ready held high ----
        mem_rdata = 64'hDEAD_BEEF;
        cpu_req = 1'b1; cpu_rw = 1'b1; cpu_addr = 64'h40;
        tick();
        check("t1_valid", 64'(mem_valid), 64'd1);
        check("t1_addr",  mem_addr, 64'h40);
        check("t1_ack_early", 64'(cpu_ack), 64'd0);
        tick();
        check("t1_ack",   64'(cpu_ack), 64'd1);
        check("t1_rdata", cpu_rdata, 64'hDEAD_BEEF);
        check("t1_ldr_ack", 64'(ldr_ack), 64'd0);
        check("t1_err",   64'(err), 64'd0);
        check("t1_valid_resp", 64'(mem_valid), 64'd0);
        cpu_req = 1'b0;
        tick();
        check("t1_ack_one", 64'({cpu_ack, mem_valid}), 64'd0);
        check("t1_hold",  cpu_rdata, 64'hDEAD_BEEF);

        // ---- both requesting from reset: CPU, loader, CPU ----
        reset = 1'b0;
        #1;
        reset = 1'b1;
        @(negedge clock);
        cpu_req = 1'b1; cpu_rw = 1'b0; cpu_addr = 64'h10; cpu_wdata = 64'h5;
        ldr_req = 1'b1; ldr_rw = 1'b0; ldr_addr = 64'h20; ldr_wdata = 64'h6;
        tick();
        check("t2_own0",  64'(owner), 64'd0);
        check("t2_addr0", mem_addr, 64'h10);
        check("t2_wd0",   mem_wdata, 64'h5);
        check("t2_rw0",   64'(mem_rw), 64'd0);
        tick();
        check("t2_ack0",  64'({cpu_ack, ldr_ack}), 64'b10);
        tick();
        check("t2_idle0", 64'(mem_valid), 64'd0);
        tick();
        check("t2_own1",  64'(owner), 64'd1);
        check("t2_addr1", mem_addr, 64'h20);
        check("t2_wd1",   mem_wdata, 64'h6);
        tick();
        check("t2_ack1",  64'({cpu_ack, ldr_ack}), 64'b01);
        tick();
        tick();
        check("t2_own2",  64'(owner), 64'd0);
        check("t2_addr2", mem_addr, 64'h10);
        tick();
        check("t2_ack2",  64'({cpu_ack, ldr_ack}), 64'b10);
        check("t2_wr_rdata", cpu_rdata | ldr_rdata, 64'd0);
        cpu_req = 1'b0; ldr_req = 1'b0;
        tick();

        // ---- loader read, ready delayed 4 cycles, req dropped mid-BUS ----
        mem_ready = 1'b0; mem_rdata = 64'h1234;
        ldr_req = 1'b1; ldr_rw = 1'b1; ldr_addr = 64'h80; ldr_wdata = 64'h77;
        tick();
        ldr_req = 1'b0; ldr_addr = 64'hFFF;
        for (int i = 0; i < 4; i++) begin
            check("t3_valid", 64'(mem_valid), 64'd1);
            check("t3_addr",  mem_addr, 64'h80);
            check("t3_wdata", mem_wdata, 64'd0);
            check("t3_noack", 64'(ldr_ack), 64'd0);
            tick();
        end
        mem_ready = 1'b1;
        check("t3_valid5", 64'(mem_valid), 64'd1);
        tick();
        mem_ready = 1'b0;
        check("t3_ack",   64'({cpu_ack, ldr_ack}), 64'b01);
        check("t3_rdata", ldr_rdata, 64'h1234);
        check("t3_cpu_rd", cpu_rdata, 64'd0);
        tick();
        check("t3_ack_off", 64'(ldr_ack), 64'd0);

        // ---- reset during BUS ----
        cpu_req = 1'b1; cpu_rw = 1'b1; cpu_addr = 64'h40;
        tick();
        check("t4_bus", 64'(mem_valid), 64'd1);
        #2;
        reset = 1'b0;
        mem_ready = 1'b1;
        #1;
        check("t4_valid", 64'(mem_valid), 64'd0);
        check("t4_acks",  64'({cpu_ack, ldr_ack}), 64'd0);
        check("t4_rdata", cpu_rdata | ldr_rdata, 64'd0);
        @(negedge clock);
        check("t4_hold", 64'({mem_valid, cpu_ack, ldr_ack}), 64'd0);
        ldr_req = 1'b1;
        reset = 1'b1;
        tick();
        check("t4_tie_owner", 64'(owner), 64'd0);
        check("t4_tie_addr",  mem_addr, 64'h40);
        cpu_req = 1'b0; ldr_req = 1'b0;
        tick();
        check("t4_ack", 64'(cpu_ack), 64'd1);
        tick();

`ifdef MEM_ARB_TIMEOUT_EN
        // ---- timeout abort: ack+err 17 cycles after req ----
        mem_ready = 1'b0;
        cpu_req = 1'b1; cpu_rw = 1'b1; cpu_addr = 64'h88;
        tick();
        for (int i = 0; i < 15; i++) begin
            check("t5_wait", 64'({cpu_ack, err}), 64'd0);
            tick();
        end
        check("t5_last_bus", 64'(mem_valid), 64'd1);
        tick();
        check("t5_ack_err", 64'({cpu_ack, err}), 64'b11);
        check("t5_rdata",   cpu_rdata, {64{1'b1}});
        cpu_req = 1'b0;
        tick();
        check("t5_err_off", 64'(err), 64'd0);

        // ---- ready exactly in the 16th BUS cycle wins ----
        mem_rdata = 64'hA5;
        cpu_req = 1'b1;
        tick();
        for (int i = 0; i < 15; i++) tick();
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        check("t6_ack_ok", 64'({cpu_ack, err}), 64'b10);
        check("t6_rdata",  cpu_rdata, 64'hA5);
        cpu_req = 1'b0;
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port memory bus arbiter that shares the single 64-bit memory port between the CPU core and a program loader/debug master. Each requester gets a request/acknowledge handshake, and the arbiter serialises their accesses onto one memory bus using round-robin fairness. It sits between the `cpu` memory outputs (address, datao, rw) and the external memory, with a loader port for image download while the core runs or is held.

## Interface
- `ADDR_W`, 64, address width.
- `DATA_W`, 64, data width.
- `TIMEOUT_CYCLES`, 16, maximum BUS-state cycles before abort (used only with timeout feature).
- `clock`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-low reset.
- `cpu_req`  in  1  CPU access request, held until `cpu_ack`.
- `cpu_rw`  in  1  1 = read, 0 = write.
- `cpu_addr`  in  ADDR_W  access address.
- `cpu_wdata`  in  DATA_W  write data.
- `cpu_ack`  out  1  one-cycle completion pulse.
- `cpu_rdata`  out  DATA_W  read data; valid with `cpu_ack`, held afterwards.
- `ldr_req`, `ldr_rw`, `ldr_addr`, `ldr_wdata`, `ldr_ack`, `ldr_rdata`: loader port, same widths and meaning as the CPU port.
- `mem_valid`  out  1  bus transaction active.
- `mem_rw`  out  1  1 = read, 0 = write.
- `mem_addr`  out  ADDR_W  bus address.
- `mem_wdata`  out  DATA_W  bus write data; forced 0 when `mem_rw`=1.
- `mem_ready`  in  1  memory completes the transaction this cycle.
- `mem_rdata`  in  DATA_W  read data, sampled when `mem_valid & mem_ready & mem_rw`.
- `owner`  out  1  0 = CPU, 1 = loader; current or last grantee.
- `err`  out  1  timeout abort flag, pulsed with the ack.

## Operation
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant it.
  - Both requesting: grant the port that is not `last_owner`.
  - On grant, latch rw/addr/wdata into internal registers, set `owner`, and go to BUS.
- BUS:
  - `mem_valid`=1 and bus fields are driven from the latched values only. Requester inputs are ignored.
  - When `mem_ready`=1, capture `mem_rdata` into the owner's rdata register (reads only) and go to RESP.
- RESP:
  - Owner's ack = 1 for exactly this cycle, and `last_owner` := `owner`. Go to IDLE.
- Deasserting a request while in BUS does not cancel the transaction; the ack still pulses.
- A request still high during the ack cycle is treated as a new request in the next IDLE.
- Write transactions leave the rdata register unchanged.
- Reset values:
  - State IDLE.
  - `mem_valid`, `cpu_ack`, `ldr_ack`, `err` = 0.
  - `mem_addr`, `mem_wdata`, `cpu_rdata`, `ldr_rdata` = 0.
  - `mem_rw` = 1.
  - `owner` = 0; `last_owner` = 1, so the CPU wins the first tie.
- Reset asserted mid-transaction: the transaction is abandoned immediately (asynchronously), with no ack and no rdata update.

## Timing
- Request sampled at edge k in IDLE → `mem_valid` high in cycle k+1.
- `mem_ready` high in cycle k+1 → ack high in cycle k+2 → IDLE after edge k+2.
- Minimum request-to-ack latency: 2 cycles. Minimum per-transaction period: 3 cycles.
- `mem_ready` delayed n cycles → ack is delayed n cycles.
- `mem_ready` outside BUS is ignored.
- Both ports requesting continuously: strict alternation, one grant per transaction.

## Configuration
- `MEM_ARB_TIMEOUT_EN` defined:
  - A BUS-state counter of width clog2(TIMEOUT_CYCLES) clears on entry to BUS.
  - If `mem_ready` is still low in the TIMEOUT_CYCLES-th BUS cycle, go to RESP with `err`=1.
  - The owner's rdata register is set to all ones (if read), and the ack pulses normally.
  - `mem_ready` arriving in that same cycle wins: normal completion, `err`=0.
- `MEM_ARB_TIMEOUT_EN` undefined:
  - BUS waits indefinitely.
  - `err` is tied 0 and no counter logic exists.

## Structure
- Package `mem_arb_pkg`: state enum (IDLE/BUS/RESP), owner encoding constants (`OWN_CPU`=0, `OWN_LDR`=1), `RW_READ`=1.
- Sub-module `mem_arb_rr`: combinational 2-way round-robin picker.
  - Inputs: two requests and `last_owner`.
  - Outputs: `grant_valid` and `grant_id`.
- The FSM, latches and timeout counter stay in the top level.

## Test plan
- CPU read, addr 0x40, `mem_ready` held 1, `mem_rdata`=0xDEAD_BEEF → `mem_valid` 1 cycle after req; `cpu_ack` 2 cycles after req; `cpu_rdata`=0xDEAD_BEEF; `ldr_ack` stays 0.
- Both requesting from reset (CPU write 0x10 ← 0x5, loader write 0x20 ← 0x6), `mem_ready`=1 → CPU served first, then loader, then CPU; `owner` toggles 0,1,0.
- Loader read with `mem_ready` delayed 4 cycles; loader drops `ldr_req` mid-BUS → `mem_addr` stays stable; `ldr_ack` 6 cycles after req; `mem_wdata`=0 throughout.
- `reset` pulled low during BUS → immediately `mem_valid`=0, both acks 0, rdata=0; first post-reset tie goes to CPU.
- With `MEM_ARB_TIMEOUT_EN`, TIMEOUT_CYCLES=16, `mem_ready` never asserted → `cpu_ack` and `err` pulse together 17 cycles after req; `cpu_rdata`=all ones.
- With `MEM_ARB_TIMEOUT_EN`, `mem_ready` asserted exactly in the 16th BUS cycle → normal ack, `err`=0, `cpu_rdata`=`mem_rdata`.
